branch_control_unit: RTL and testbench
======================================

// Module: branch_control_unit
// PURPOSE
//  Branch predictor and misprediction recovery for the pipelined RISC-V core. Predicts each
//  ID-stage branch with a table of 2-bit saturating counters, compares the prediction with the
//  EX-stage comparator outcome, then sequences PC redirect and IF/ID + ID/EX flush.
//  Also trains the table and counts branches and mispredictions.
// PARAMETERS
//  XLEN            64  data/address width
//  BHT_ENTRIES     16  predictor entries; power of 2, >= 2
//  RECOVER_CYCLES  2   cycles after REDIRECT during which EX branches are ignored (0 allowed)
//  CNT_W           32  width of performance counters
// PORTS
//  clk             in   1       clock, rising edge
//  reset           in   1       asynchronous, active-high
//  id_valid        in   1       ID-stage instruction valid
//  id_is_branch    in   1       ID-stage instruction is a conditional branch
//  id_pc           in   XLEN    ID-stage PC
//  id_imm          in   XLEN    branch byte offset, sign-extended
//  pred_taken      out  1       prediction for ID branch (comb)
//  pred_target     out  XLEN    id_pc + id_imm (comb)
//  ex_valid        in   1       EX-stage instruction valid
//  ex_is_branch    in   1       EX-stage instruction is a conditional branch
//  ex_funct3       in   3       branch funct3 in EX
//  ex_pc           in   XLEN    EX-stage PC
//  ex_target       in   XLEN    computed branch target in EX
//  ex_pred_taken   in   1       prediction carried down the pipe
//  ex_taken        in   1       comparator result from the branching unit
//  redirect_valid  out  1       load redirect_pc into PC this cycle
//  redirect_pc     out  XLEN    corrected fetch address
//  flush_if_id     out  1       squash IF/ID register
//  flush_id_ex     out  1       squash ID/EX register
//  branch_count    out  CNT_W   resolved branches, saturating
//  mispred_count   out  CNT_W   mispredictions, saturating
// BEHAVIOUR
//  - Reset: all outputs 0 except pred_*; state RUN; recover counter 0; every BHT entry 2'b01.
//  - Index = pc[$clog2(BHT_ENTRIES)+1:2]; pred_taken = entry[1] when id_valid & id_is_branch, else 0.
//  - Resolve (only in RUN): ex_valid & ex_is_branch & ex_funct3 in {000,100,101}. Other funct3
//    values: no update, no count, no redirect.
//  - On resolve, at the clock edge: entry[ex index] inc (sat 11) if ex_taken else dec (sat 00);
//    branch_count++ (sat at all-ones).
//  - Mispredict = resolve & (ex_taken != ex_pred_taken): mispred_count++ (sat); state -> REDIRECT.
//  - REDIRECT (exactly 1 cycle, registered outputs): redirect_valid = flush_if_id = flush_id_ex = 1;
//    redirect_pc = ex_target if ex_taken else ex_pc + 4 (mod 2^XLEN), captured at detection.
//    Next: RECOVER with counter = RECOVER_CYCLES, or RUN if RECOVER_CYCLES == 0.
//  - RECOVER: all control outputs 0; EX branches ignored (no update/count); counter decrements;
//    at 1 -> RUN. Latency mispredict-in-EX to redirect_valid: 1 cycle.
//  - Table read and write to the same index in one cycle: read returns pre-update value.
//  - Reset asserted in any state: immediate return to reset values, including BHT and counters.
// TESTING
//  1 Reset, then branch at pc 0x100 in ID -> pred_taken = 0, pred_target = 0x100 + id_imm.
//  2 Three resolved taken branches at pc 0x100, ex_pred_taken = pred -> entry 01->10->11->11;
//    first one mispredicts, redirect_pc = ex_target, 1-cycle pulse on redirect and both flushes.
//  3 Predicted taken, ex_taken = 0, ex_pc = 0x200 -> next cycle redirect_pc = 0x204,
//    mispred_count +1; EX branch in the following 2 cycles produces no update or count.
//  4 ex_funct3 = 3'b001 with ex_taken = 1 -> no redirect, counters and BHT unchanged.
//  5 CNT_W = 4, 20 resolves -> branch_count holds 4'hF; reset asserted during RECOVER ->
//    all outputs 0 asynchronously, BHT back to 01.
//  6 Same-index ID read and EX update in one cycle -> pred_taken reflects old entry; new value next cycle.

Source files
------------

// File: rtl/branch_control_unit.sv
// Branch predictor (2-bit BHT) with mispredict redirect/flush sequencing.
// Trains the table and keeps saturating branch/mispredict counters.
module branch_control_unit #(
  parameter int XLEN           = 64,
  parameter int BHT_ENTRIES    = 16,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic             ex_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int RW = (RECOVER_CYCLES < 2) ? 1
                    : $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    RECOVER
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [IW-1:0]   id_idx, ex_idx;
  logic [1:0]      ex_ent, ex_nxt;
  logic            br_op, resolve, mispred;
  logic            redir_q;
  logic [XLEN-1:0] rpc_q;
  logic [CNT_W-1:0] bcnt_q, mcnt_q;

  assign id_idx = id_pc[IW+1:2];
  assign ex_idx = ex_pc[IW+1:2];

  assign pred_target = id_pc + id_imm;
  assign pred_taken  = id_valid & id_is_branch
                     & bht_q[id_idx][1];

  assign br_op = (ex_funct3 == 3'b000)
               | (ex_funct3 == 3'b100)
               | (ex_funct3 == 3'b101);

  assign resolve = (state_q == RUN) & ex_valid
                 & ex_is_branch & br_op;
  assign mispred = resolve & (ex_taken != ex_pred_taken);

  assign ex_ent = bht_q[ex_idx];

  always_comb begin
    ex_nxt = ex_ent;
    if (ex_taken) begin
      if (ex_ent != 2'b11) ex_nxt = ex_ent + 2'b01;
    end else begin
      if (ex_ent != 2'b00) ex_nxt = ex_ent - 2'b01;
    end
  end

  // Reads are combinational, so a same-cycle update shows next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= 2'b01;
    end else if (resolve) begin
      bht_q[ex_idx] <= ex_nxt;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      RUN: begin
        if (mispred) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (RECOVER_CYCLES == 0) begin
          state_d = RUN;
        end else begin
          state_d = RECOVER;
          rcnt_d  = RW'(RECOVER_CYCLES);
        end
      end
      RECOVER: begin
        rcnt_d = rcnt_q - 1'b1;
        if (rcnt_q <= RW'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rcnt_q  <= '0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      redir_q <= (state_d == REDIRECT);
      if (mispred)
        rpc_q <= ex_taken ? ex_target
                          : ex_pc + XLEN'(4);
      else
        rpc_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (resolve && bcnt_q != '1)
        bcnt_q <= bcnt_q + 1'b1;
      if (mispred && mcnt_q != '1)
        mcnt_q <= mcnt_q + 1'b1;
    end
  end

  assign redirect_valid = redir_q;
  assign flush_if_id    = redir_q;
  assign flush_id_ex    = redir_q;
  assign redirect_pc    = rpc_q;
  assign branch_count   = bcnt_q;
  assign mispred_count  = mcnt_q;

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed bench for branch_control_unit.
// Redirect targets are checked by a queue-fed monitor.
module tb_branch_control_unit;

  logic        clk;
  logic        reset;
  logic        id_valid, id_is_branch;
  logic [63:0] id_pc, id_imm;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid, ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_pc, ex_target;
  logic        ex_pred_taken, ex_taken;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush_if_id, flush_id_ex;
  logic [3:0]  branch_count, mispred_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  branch_control_unit #(
    .XLEN(64), .BHT_ENTRIES(16),
    .RECOVER_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid),
    .id_is_branch(id_is_branch),
    .id_pc(id_pc), .id_imm(id_imm),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex),
    .branch_count(branch_count),
    .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic [63:0] pc,
                          input logic [2:0]  f3,
                          input logic        tk,
                          input logic        pt,
                          input logic [63:0] tgt);
    ex_valid      = 1'b1;
    ex_is_branch  = 1'b1;
    ex_pc         = pc;
    ex_funct3     = f3;
    ex_taken      = tk;
    ex_pred_taken = pt;
    ex_target     = tgt;
  endtask

  task automatic id_drive(input logic [63:0] pc,
                          input logic [63:0] imm);
    id_valid     = 1'b1;
    id_is_branch = 1'b1;
    id_pc        = pc;
    id_imm       = imm;
  endtask

  task automatic counts(input string nm,
                        input logic [3:0] b,
                        input logic [3:0] m);
    chk({nm, "_bcnt"}, 64'(branch_count), 64'(b));
    chk({nm, "_mcnt"}, 64'(mispred_count), 64'(m));
  endtask

  // Monitor: flushes track redirect; each redirect pops one target
  always @(negedge clk) begin
    checks++;
    if ({flush_if_id, flush_id_ex}
        !== {redirect_valid, redirect_valid}) begin
      errors++;
      $display("FAIL flush got %b%b want %b%b",
               flush_if_id, flush_id_ex,
               redirect_valid, redirect_valid);
    end
    if (redirect_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL redir_unexp got %h want none",
                 redirect_pc);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if (redirect_pc !== e) begin
          errors++;
          $display("FAIL redir_pc got %h want %h",
                   redirect_pc, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    id_valid = 0; id_is_branch = 0;
    id_pc = '0; id_imm = '0;
    ex_valid = 0; ex_is_branch = 0;
    ex_funct3 = '0; ex_pc = '0; ex_target = '0;
    ex_pred_taken = 0; ex_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rv", 64'(redirect_valid), 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    counts("rst", 4'd0, 4'd0);
    reset = 1'b0;

    // 1: fresh prediction and target
    id_drive(64'h100, 64'h40);
    #1;
    chk("t1_pred", 64'(pred_taken), 64'd0);
    chk("t1_tgt", pred_target, 64'h140);
    id_imm = 64'hFFFF_FFFF_FFFF_FFF8;
    #1;
    chk("t1_tgt_neg", pred_target, 64'hF8);

    // 2: three taken resolves at 0x100
    ex_drive(64'h100, 3'b000, 1'b1, 1'b0, 64'h300);
    sb.push_back(64'h300);
    step();
    ex_valid = 1'b0;
    chk("t2_rv", 64'(redirect_valid), 64'd1);
    chk("t2_pred10", 64'(pred_taken), 64'd1);
    step();
    chk("t2_rv_off", 64'(redirect_valid), 64'd0);
    step(); step();
    ex_drive(64'h100, 3'b000, 1'b1, 1'b1, 64'h300);
    step(); step();
    ex_valid = 1'b0;
    #1;
    chk("t2_pred11", 64'(pred_taken), 64'd1);
    counts("t2", 4'd3, 4'd1);

    // 3: not-taken mispredict, EX ignored in recovery
    ex_drive(64'h200, 3'b000, 1'b0, 1'b1, 64'h999);
    sb.push_back(64'h204);
    step(); step(); step(); step();
    ex_valid = 1'b0;
    #1;
    counts("t3", 4'd4, 4'd2);
    chk("t3_pred", 64'(pred_taken), 64'd1);

    // 4: funct3 filter, then bge/blt resolve
    id_drive(64'h104, 64'h0);
    ex_drive(64'h104, 3'b001, 1'b1, 1'b0, 64'h777);
    step();
    ex_valid = 1'b0;
    #1;
    counts("t4a", 4'd4, 4'd2);
    chk("t4_pred", 64'(pred_taken), 64'd0);
    ex_drive(64'h108, 3'b101, 1'b0, 1'b0, 64'h0);
    step();
    ex_drive(64'h108, 3'b100, 1'b1, 1'b0, 64'h500);
    sb.push_back(64'h500);
    step();
    ex_valid = 1'b0;
    #1;
    counts("t4b", 4'd6, 4'd3);
    step(); step(); step();
    id_pc = 64'h108;
    #1;
    chk("t4_pred108", 64'(pred_taken), 64'd0);

    // 6: same-index read during update
    id_pc = 64'h104;
    ex_drive(64'h144, 3'b000, 1'b1, 1'b1, 64'h0);
    #1;
    chk("t6_old", 64'(pred_taken), 64'd0);
    step();
    ex_valid = 1'b0;
    #1;
    chk("t6_new", 64'(pred_taken), 64'd1);
    counts("t6", 4'd7, 4'd3);

    // 5: reset during RECOVER, then saturation
    ex_drive(64'h100, 3'b000, 1'b1, 1'b0, 64'h600);
    sb.push_back(64'h600);
    step();
    ex_valid = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rv", 64'(redirect_valid), 64'd0);
    chk("t5_rpc", redirect_pc, 64'd0);
    counts("t5rst", 4'd0, 4'd0);
    step();
    reset = 1'b0;
    id_pc = 64'h104;
    #1;
    chk("t5_bht104", 64'(pred_taken), 64'd0);
    id_pc = 64'h100;
    #1;
    chk("t5_bht100", 64'(pred_taken), 64'd0);
    ex_drive(64'h10C, 3'b000, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 13)
        chk("t5_b14", 64'(branch_count), 64'd14);
    end
    ex_valid = 1'b0;
    #1;
    counts("t5sat", 4'hF, 4'd0);

    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
